sram_dump_streamer: RTL
=======================

Name: sram_dump_streamer

Overview:
Downstream stage of the screen-capture SRAM writer. Once a capture is complete (WriteFinish_Flag high), it walks the SRAM read address from 0 to PIXEL_WORDS-1 and samples each 16-bit Data_Chunk. Each word is buffered in a small word FIFO and serialised as bytes (high byte first) on a valid/ready stream toward the Nios/host link. When every byte has been accepted, it raises Nios_Finish_Reading_Flag, which the writer uses to re-arm capture.

Parameters:
- PIXEL_WORDS, 614400, number of 16-bit SRAM words in one capture; last address = PIXEL_WORDS-1.
- ADDR_W, 20, SRAM address width.
- SRAM_LAT, 2, Main_CLK cycles from a Read_Address change to a valid Data_Chunk; legal range 1..7.
- FIFO_DEPTH, 8, word FIFO depth; power of 2, at least 2.

Ports:
- Main_CLK  in  1  system clock; all state is clocked on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- WriteFinish_Flag  in  1  high while a completed capture is held in SRAM.
- Data_Chunk  in  16  SRAM read data.
- Read_Address  out  ADDR_W  SRAM read address.
- Byte_Data  out  8  streamed byte.
- Byte_Valid  out  1  Byte_Data is valid.
- Byte_Ready  in  1  sink accepts the byte; a transfer occurs when Byte_Valid and Byte_Ready are both high on a clock edge.
- Nios_Finish_Reading_Flag  out  1  dump complete.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, Reset=0):
  - FSM to IDLE; Read_Address=0; FIFO emptied; byte serialiser emptied.
  - Byte_Valid=0, Byte_Data=0, Nios_Finish_Reading_Flag=0, Busy=0.
- Start condition: a registered rising edge of WriteFinish_Flag, detected in IDLE. A level that is already high when reset is released does not start a dump.
- FSM states:
  - IDLE: on start -> ISSUE with Read_Address=0.
  - ISSUE: if FIFO count + 1 <= FIFO_DEPTH (space reserved for the single outstanding read), load the wait counter with SRAM_LAT-1 and go to WAIT. Otherwise stay in ISSUE.
  - WAIT: decrement the counter each cycle. At 0, push Data_Chunk into the FIFO that same edge.
    - If Read_Address == PIXEL_WORDS-1 -> DRAIN.
    - Else Read_Address += 1 -> ISSUE.
  - DRAIN: stay until the FIFO is empty, the serialiser is empty and Byte_Valid=0 -> DONE.
  - DONE: Nios_Finish_Reading_Flag=1 (registered). Hold until WriteFinish_Flag=0, then clear the flag and go to IDLE.
- Read rules:
  - Only one read is outstanding at a time.
  - Read_Address is held constant from ISSUE through the sample edge.
  - Per-word cadence is SRAM_LAT+1 cycles when the FIFO is not full.
- Abort: WriteFinish_Flag=0 in ISSUE, WAIT or DRAIN -> next edge: flush FIFO and serialiser, Byte_Valid=0, Read_Address=0, IDLE. Nios_Finish_Reading_Flag is not asserted.
- Serialiser:
  - When empty and the FIFO is non-empty, pop a word.
  - Present [15:8] first with Byte_Valid=1, then [7:0].
  - Byte_Data and Byte_Valid are held stable while Byte_Ready=0.
  - Back-to-back bytes are allowed: 1 byte/cycle while Byte_Ready=1 and data is available.
  - A FIFO pop and a FIFO push in the same cycle are both honoured, and the count is unchanged.
  - Total bytes per dump = 2*PIXEL_WORDS, sent in address order.
- Read_Address wraps never: the last address is PIXEL_WORDS-1 and no read is issued beyond it.
- A new start is only possible after returning to IDLE.

Test Plan:
- Basic dump: PIXEL_WORDS=4, SRAM_LAT=2, SRAM model returns 16'hA000+addr, Byte_Ready=1, pulse WriteFinish_Flag high and hold -> bytes A0,00,A0,01,A0,02,A0,03 in order; Read_Address never exceeds 3; Nios_Finish_Reading_Flag rises after the last byte; drop WriteFinish_Flag -> flag clears next cycle, Busy=0.
- Backpressure: PIXEL_WORDS=16, FIFO_DEPTH=4, Byte_Ready=0 for 40 cycles -> Read_Address stalls once FIFO count reaches 4; Byte_Data stays at the first byte; after release all 32 bytes arrive with none lost or duplicated.
- Random Byte_Ready (50%) with SRAM_LAT=1, PIXEL_WORDS=64 -> the 128-byte stream matches the scoreboard exactly.
- Abort: deassert WriteFinish_Flag while Read_Address=5 -> Byte_Valid=0 next cycle, Read_Address=0, FSM IDLE, Nios_Finish_Reading_Flag never set; a later rising edge restarts from address 0.
- Async reset mid-WAIT: assert Reset between clock edges -> all outputs at reset values immediately; after release with WriteFinish_Flag already high, no dump starts until it goes low then high.
- Latency sweep SRAM_LAT=1..4: the first Byte_Valid appears SRAM_LAT+2 cycles after the detected edge; the word captured equals the model data for the held address.

Source files
------------

// File: rtl/sram_dump_streamer.sv
// sram_dump_streamer: after a completed capture, reads the frame out of SRAM
// word by word and streams it as bytes (high byte first) over valid/ready.
module sram_dump_streamer #(
    parameter int unsigned PIXEL_WORDS = 614400,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned SRAM_LAT    = 2,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic              Main_CLK,
    input  logic              Reset,
    input  logic              WriteFinish_Flag,
    input  logic [15:0]       Data_Chunk,
    output logic [ADDR_W-1:0] Read_Address,
    output logic [7:0]        Byte_Data,
    output logic              Byte_Valid,
    input  logic              Byte_Ready,
    output logic              Nios_Finish_Reading_Flag,
    output logic              Busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = 3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_WORDS - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(SRAM_LAT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic              wf_q;
    logic [LAT_W-1:0]  wait_cnt;

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic [7:0]        lo_byte;
    logic              lo_pend;

    logic              start;
    logic              active;
    logic              abort;
    logic              fifo_empty;
    logic              push;
    logic              out_free;
    logic              pop;

    // Control strobes decoded from the current state and the byte handshake
    always_comb begin
        start      = (state == S_IDLE) && WriteFinish_Flag && !wf_q;
        active     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN);
        abort      = active && !WriteFinish_Flag;
        fifo_empty = (fifo_cnt == '0);
        push       = (state == S_WAIT) && (wait_cnt == '0) && !abort;
        out_free   = !Byte_Valid || Byte_Ready;
        pop        = out_free && !lo_pend && !fifo_empty && !abort;
    end

    assign Busy = (state != S_IDLE);

    // Dump sequencer: address walk, SRAM latency wait and completion flag.
    // wf_q resets high so a flag already high at reset release is not an edge.
    always_ff @(posedge Main_CLK or negedge Reset) begin
        if (!Reset) begin
            state                    <= S_IDLE;
            wf_q                     <= 1'b1;
            wait_cnt                 <= '0;
            Read_Address             <= '0;
            Nios_Finish_Reading_Flag <= 1'b0;
        end else begin
            wf_q <= WriteFinish_Flag;
            if (abort) begin
                state        <= S_IDLE;
                Read_Address <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state        <= S_ISSUE;
                            Read_Address <= '0;
                        end
                    end
                    S_ISSUE: begin
                        if (fifo_cnt < DEPTH_C) begin
                            wait_cnt <= LAT_LOAD;
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (wait_cnt == '0) begin
                            if (Read_Address == LAST_ADDR) begin
                                state <= S_DRAIN;
                            end else begin
                                Read_Address <= Read_Address + ADDR_W'(1);
                                state        <= S_ISSUE;
                            end
                        end else begin
                            wait_cnt <= wait_cnt - LAT_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (fifo_empty && !lo_pend && !Byte_Valid) begin
                            state                    <= S_DONE;
                            Nios_Finish_Reading_Flag <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (!WriteFinish_Flag) begin
                            state                    <= S_IDLE;
                            Nios_Finish_Reading_Flag <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Word FIFO pointers and occupancy; an abort discards everything buffered
    always_ff @(posedge Main_CLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Word FIFO storage, written with the sampled SRAM data
    always_ff @(posedge Main_CLK) begin
        if (push) fifo_mem[wr_ptr] <= Data_Chunk;
    end

    // Byte serialiser: high byte from the popped word, then the parked low byte
    always_ff @(posedge Main_CLK or negedge Reset) begin
        if (!Reset) begin
            Byte_Valid <= 1'b0;
            Byte_Data  <= '0;
            lo_byte    <= '0;
            lo_pend    <= 1'b0;
        end else if (abort) begin
            Byte_Valid <= 1'b0;
            Byte_Data  <= '0;
            lo_pend    <= 1'b0;
        end else if (out_free) begin
            if (lo_pend) begin
                Byte_Data  <= lo_byte;
                Byte_Valid <= 1'b1;
                lo_pend    <= 1'b0;
            end else if (!fifo_empty) begin
                Byte_Data  <= fifo_mem[rd_ptr][15:8];
                lo_byte    <= fifo_mem[rd_ptr][7:0];
                lo_pend    <= 1'b1;
                Byte_Valid <= 1'b1;
            end else begin
                Byte_Valid <= 1'b0;
            end
        end
    end

endmodule
